a2mem_switch_tracker: RTL and testbench

Bus-snooping soft-switch tracker that drives the master side of the Apple II memory interface. It watches every completed 6502 bus cycle, decodes accesses to the $C0xx soft-switch space and the $Cnxx slot-ROM space, and maintains the registered video, auxiliary-memory, slot-ROM, IIgs colour/mode and keyboard state that video and memory consumers read through the slave modport. Videx CRTC signals are not driven here.

---
 rtl/a2mem_pkg.sv | 36 +++
 rtl/a2mem_if.sv | 52 +++++
 rtl/a2mem_aux_decode.sv | 28 ++
 rtl/a2mem_switch_tracker.sv | 196 +++++++++++++++++++
 tb/tb_a2mem_switch_tracker.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/a2mem_pkg.sv
// a2mem_pkg: shared constants and types for the Apple II soft-switch tracker.
// Holds the soft-switch addresses, IIgs colour reset values and the packed
// struct for the eight write-only IIe auxiliary switches.
package a2mem_pkg;

  localparam logic [15:0] ADDR_C000 = 16'hC000;  // write switches / keyboard data
  localparam logic [15:0] ADDR_C010 = 16'hC010;  // keyboard strobe clear
  localparam logic [15:0] ADDR_C050 = 16'hC050;  // video soft switches
  localparam logic [15:0] ADDR_CFFF = 16'hCFFF;  // expansion ROM release
  localparam logic [15:0] ADDR_C021 = 16'hC021;  // IIgs MONOCOLOR
  localparam logic [15:0] ADDR_C022 = 16'hC022;  // IIgs TBCOLOR
  localparam logic [15:0] ADDR_C029 = 16'hC029;  // IIgs NEWVIDEO
  localparam logic [15:0] ADDR_C034 = 16'hC034;  // IIgs CLOCKCTL (border)

  localparam logic [3:0] TEXT_COLOR_RST       = 4'hF;
  localparam logic [3:0] BACKGROUND_COLOR_RST = 4'h6;
  localparam logic [3:0] BORDER_COLOR_RST     = 4'h6;

  // store80 is bit 0 so that address bits [3:1] index the struct directly
  typedef struct packed {
    logic altchar;
    logic col80;
    logic slotc3rom;
    logic altzp;
    logic intcxrom;
    logic ramwrt;
    logic ramrd;
    logic store80;
  } iie_sw_t;

  // True when addr lies in the same 16-byte block as base
  function automatic logic in_block16(input logic [15:0] addr, input logic [15:0] base);
    return addr[15:4] == base[15:4];
  endfunction

endpackage

// File: rtl/a2mem_if.sv
// a2mem_if: memory/video state bundle between the switch tracker (master)
// and its video and memory consumers (slave).
interface a2mem_if;

  logic       TEXT_MODE;
  logic       MIXED_MODE;
  logic       PAGE2;
  logic       HIRES_MODE;
  logic       AN0;
  logic       AN1;
  logic       AN2;
  logic       AN3;
  logic       STORE80;
  logic       RAMRD;
  logic       RAMWRT;
  logic       INTCXROM;
  logic       ALTZP;
  logic       SLOTC3ROM;
  logic       COL80;
  logic       ALTCHAR;
  logic       INTC8ROM;
  logic [2:0] SLOTROM;
  logic       SHRG_MODE;
  logic       MONOCHROME_MODE;
  logic       LINEARIZE_MODE;
  logic       MONOCHROME_DHIRES_MODE;
  logic [3:0] TEXT_COLOR;
  logic [3:0] BACKGROUND_COLOR;
  logic [3:0] BORDER_COLOR;
  logic       aux_mem;
  logic [7:0] keycode;
  logic       keypress_strobe;

  modport master (
    output TEXT_MODE, MIXED_MODE, PAGE2, HIRES_MODE, AN0, AN1, AN2, AN3,
    output STORE80, RAMRD, RAMWRT, INTCXROM, ALTZP, SLOTC3ROM, COL80, ALTCHAR,
    output INTC8ROM, SLOTROM,
    output SHRG_MODE, MONOCHROME_MODE, LINEARIZE_MODE, MONOCHROME_DHIRES_MODE,
    output TEXT_COLOR, BACKGROUND_COLOR, BORDER_COLOR,
    output aux_mem, keycode, keypress_strobe
  );

  modport slave (
    input TEXT_MODE, MIXED_MODE, PAGE2, HIRES_MODE, AN0, AN1, AN2, AN3,
    input STORE80, RAMRD, RAMWRT, INTCXROM, ALTZP, SLOTC3ROM, COL80, ALTCHAR,
    input INTC8ROM, SLOTROM,
    input SHRG_MODE, MONOCHROME_MODE, LINEARIZE_MODE, MONOCHROME_DHIRES_MODE,
    input TEXT_COLOR, BACKGROUND_COLOR, BORDER_COLOR,
    input aux_mem, keycode, keypress_strobe
  );

endinterface

// File: rtl/a2mem_aux_decode.sv
// a2mem_aux_decode: decides whether the current access targets auxiliary
// memory, using the switch state as it stood before this access.
module a2mem_aux_decode
  import a2mem_pkg::*;
(
  input  logic [15:0] addr_i,
  input  logic        rw_n_i,
  input  iie_sw_t     sw_i,
  input  logic        page2_i,
  input  logic        hires_i,
  output logic        aux_mem_o
);

  // Priority decode: zero page/stack and LC space, then 80STORE display pages, then I/O, then RAMRD/RAMWRT
  always_comb begin
    aux_mem_o = rw_n_i ? sw_i.ramrd : sw_i.ramwrt;
    if (addr_i <= 16'h01FF || addr_i >= 16'hD000) begin
      aux_mem_o = sw_i.altzp;
    end else if (addr_i[15:10] == 6'b000001 && sw_i.store80) begin
      aux_mem_o = page2_i;
    end else if (addr_i[15:13] == 3'b001 && sw_i.store80 && hires_i) begin
      aux_mem_o = page2_i;
    end else if (addr_i[15:12] == 4'hC) begin
      aux_mem_o = 1'b0;
    end
  end

endmodule

// File: rtl/a2mem_switch_tracker.sv
// a2mem_switch_tracker: snoops completed 6502 bus cycles and keeps the
// Apple II soft-switch, slot-ROM, aux-memory and keyboard state.
// Optional IIgs colour/mode registers are compiled in with A2MEM_IIGS_REGS_EN.
module a2mem_switch_tracker
  import a2mem_pkg::*;
(
  input  logic        clk_logic_i,
  input  logic        system_reset_n_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  data_i,
  input  logic        rw_n_i,
  input  logic        data_in_strobe_i,
  a2mem_if.master     a2mem_if
);

  iie_sw_t    sw_q, sw_d;
  logic [7:0] video_q, video_d;   // TEXT, MIXED, PAGE2, HIRES, AN0..AN3
  logic       intc8rom_q, intc8rom_d;
  logic [2:0] slotrom_q, slotrom_d;
  logic       aux_mem_q, aux_mem_d;
  logic       aux_mem_c;
  logic [7:0] keycode_q, keycode_d;
  logic       key_pending_q, key_pending_d;
  logic       keypress_strobe_q, keypress_strobe_d;
  logic [7:0] sw_bits;

  a2mem_aux_decode u_aux_decode (
    .addr_i    (addr_i),
    .rw_n_i    (rw_n_i),
    .sw_i      (sw_q),
    .page2_i   (video_q[2]),
    .hires_i   (video_q[3]),
    .aux_mem_o (aux_mem_c)
  );

  // Next-state for switches, slot ROM, aux flag and keyboard on each bus strobe
  always_comb begin
    sw_d              = sw_q;
    video_d           = video_q;
    intc8rom_d        = intc8rom_q;
    slotrom_d         = slotrom_q;
    aux_mem_d         = aux_mem_q;
    keycode_d         = keycode_q;
    key_pending_d     = key_pending_q;
    keypress_strobe_d = 1'b0;
    sw_bits           = sw_q;
    if (data_in_strobe_i) begin
      aux_mem_d = aux_mem_c;
      if (!rw_n_i && in_block16(addr_i, ADDR_C000)) begin
        sw_bits[addr_i[3:1]] = addr_i[0];
        sw_d = iie_sw_t'(sw_bits);
      end
      if (in_block16(addr_i, ADDR_C050)) begin
        video_d[addr_i[3:1]] = addr_i[0];
      end
      if (addr_i == ADDR_CFFF) begin
        intc8rom_d = 1'b0;
        slotrom_d  = 3'd0;
      end else if (addr_i[15:12] == 4'hC && !addr_i[11] && addr_i[10:8] != 3'd0) begin
        if (addr_i[10:8] == 3'd3 && !sw_q.slotc3rom) begin
          intc8rom_d = 1'b1;
        end else if (!sw_q.intcxrom) begin
          slotrom_d = addr_i[10:8];
        end
      end
      if (rw_n_i && in_block16(addr_i, ADDR_C000) && data_i[7] && !key_pending_q) begin
        keycode_d         = data_i;
        key_pending_d     = 1'b1;
        keypress_strobe_d = 1'b1;
      end
      if (in_block16(addr_i, ADDR_C010)) begin
        key_pending_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
    if (!system_reset_n_i) begin
      sw_q              <= '0;
      video_q           <= 8'h01;
      intc8rom_q        <= 1'b0;
      slotrom_q         <= 3'd0;
      aux_mem_q         <= 1'b0;
      keycode_q         <= 8'h00;
      key_pending_q     <= 1'b0;
      keypress_strobe_q <= 1'b0;
    end else begin
      sw_q              <= sw_d;
      video_q           <= video_d;
      intc8rom_q        <= intc8rom_d;
      slotrom_q         <= slotrom_d;
      aux_mem_q         <= aux_mem_d;
      keycode_q         <= keycode_d;
      key_pending_q     <= key_pending_d;
      keypress_strobe_q <= keypress_strobe_d;
    end
  end

  assign a2mem_if.TEXT_MODE       = video_q[0];
  assign a2mem_if.MIXED_MODE      = video_q[1];
  assign a2mem_if.PAGE2           = video_q[2];
  assign a2mem_if.HIRES_MODE      = video_q[3];
  assign a2mem_if.AN0             = video_q[4];
  assign a2mem_if.AN1             = video_q[5];
  assign a2mem_if.AN2             = video_q[6];
  assign a2mem_if.AN3             = video_q[7];
  assign a2mem_if.STORE80         = sw_q.store80;
  assign a2mem_if.RAMRD           = sw_q.ramrd;
  assign a2mem_if.RAMWRT          = sw_q.ramwrt;
  assign a2mem_if.INTCXROM        = sw_q.intcxrom;
  assign a2mem_if.ALTZP           = sw_q.altzp;
  assign a2mem_if.SLOTC3ROM       = sw_q.slotc3rom;
  assign a2mem_if.COL80           = sw_q.col80;
  assign a2mem_if.ALTCHAR         = sw_q.altchar;
  assign a2mem_if.INTC8ROM        = intc8rom_q;
  assign a2mem_if.SLOTROM         = slotrom_q;
  assign a2mem_if.aux_mem         = aux_mem_q;
  assign a2mem_if.keycode         = keycode_q;
  assign a2mem_if.keypress_strobe = keypress_strobe_q;

`ifdef A2MEM_IIGS_REGS_EN
  logic       mono_q, mono_d;
  logic [3:0] text_color_q, text_color_d;
  logic [3:0] bg_color_q, bg_color_d;
  logic       shrg_q, shrg_d;
  logic       linearize_q, linearize_d;
  logic       mono_dhires_q, mono_dhires_d;
  logic [3:0] border_color_q, border_color_d;

  // IIgs video registers update only on writes to their addresses
  always_comb begin
    mono_d         = mono_q;
    text_color_d   = text_color_q;
    bg_color_d     = bg_color_q;
    shrg_d         = shrg_q;
    linearize_d    = linearize_q;
    mono_dhires_d  = mono_dhires_q;
    border_color_d = border_color_q;
    if (data_in_strobe_i && !rw_n_i) begin
      case (addr_i)
        ADDR_C021: mono_d = data_i[7];
        ADDR_C022: begin
          text_color_d = data_i[7:4];
          bg_color_d   = data_i[3:0];
        end
        ADDR_C029: begin
          shrg_d        = data_i[7];
          linearize_d   = data_i[6];
          mono_dhires_d = data_i[5];
        end
        ADDR_C034: border_color_d = data_i[3:0];
        default: ;
      endcase
    end
  end

  // IIgs register storage with asynchronous active-low reset
  always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
    if (!system_reset_n_i) begin
      mono_q         <= 1'b0;
      text_color_q   <= TEXT_COLOR_RST;
      bg_color_q     <= BACKGROUND_COLOR_RST;
      shrg_q         <= 1'b0;
      linearize_q    <= 1'b0;
      mono_dhires_q  <= 1'b0;
      border_color_q <= BORDER_COLOR_RST;
    end else begin
      mono_q         <= mono_d;
      text_color_q   <= text_color_d;
      bg_color_q     <= bg_color_d;
      shrg_q         <= shrg_d;
      linearize_q    <= linearize_d;
      mono_dhires_q  <= mono_dhires_d;
      border_color_q <= border_color_d;
    end
  end

  assign a2mem_if.MONOCHROME_MODE        = mono_q;
  assign a2mem_if.TEXT_COLOR             = text_color_q;
  assign a2mem_if.BACKGROUND_COLOR       = bg_color_q;
  assign a2mem_if.SHRG_MODE              = shrg_q;
  assign a2mem_if.LINEARIZE_MODE         = linearize_q;
  assign a2mem_if.MONOCHROME_DHIRES_MODE = mono_dhires_q;
  assign a2mem_if.BORDER_COLOR           = border_color_q;
`else
  assign a2mem_if.MONOCHROME_MODE        = 1'b0;
  assign a2mem_if.TEXT_COLOR             = TEXT_COLOR_RST;
  assign a2mem_if.BACKGROUND_COLOR       = BACKGROUND_COLOR_RST;
  assign a2mem_if.SHRG_MODE              = 1'b0;
  assign a2mem_if.LINEARIZE_MODE         = 1'b0;
  assign a2mem_if.MONOCHROME_DHIRES_MODE = 1'b0;
  assign a2mem_if.BORDER_COLOR           = BORDER_COLOR_RST;
`endif

endmodule

// File: tb/tb_a2mem_switch_tracker.sv
// tb_a2mem_switch_tracker: table-driven bench with a scoreboard queue for the
// soft-switch tracker; IIgs expectations follow A2MEM_IIGS_REGS_EN.
module tb_a2mem_switch_tracker;

  typedef struct packed {
    logic       store80;
    logic       ramrd;
    logic       ramwrt;
    logic       altzp;
    logic       col80;
    logic       text_mode;
    logic       page2;
    logic       hires;
    logic       intc8rom;
    logic [2:0] slotrom;
    logic       aux_mem;
    logic [7:0] keycode;
    logic       kstrobe;
    logic [3:0] text_color;
    logic [3:0] bg_color;
    logic [3:0] border_color;
    logic       shrg;
    logic       linearize;
  } obs_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n;
    obs_t        exp;
  } vec_t;

  localparam obs_t RST = '{store80: 1'b0, ramrd: 1'b0, ramwrt: 1'b0, altzp: 1'b0,
                           col80: 1'b0, text_mode: 1'b1, page2: 1'b0, hires: 1'b0,
                           intc8rom: 1'b0, slotrom: 3'd0, aux_mem: 1'b0,
                           keycode: 8'h00, kstrobe: 1'b0, text_color: 4'hF,
                           bg_color: 4'h6, border_color: 4'h6, shrg: 1'b0,
                           linearize: 1'b0};

`ifdef A2MEM_IIGS_REGS_EN
  localparam bit IIGS = 1'b1;
`else
  localparam bit IIGS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  data = 8'h00;
  logic        rw_n = 1'b1;
  logic        strobe = 1'b0;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  vec_t vecs[$];

  a2mem_if bus ();

  a2mem_switch_tracker dut (
    .clk_logic_i      (clk),
    .system_reset_n_i (rst_n),
    .addr_i           (addr),
    .data_i           (data),
    .rw_n_i           (rw_n),
    .data_in_strobe_i (strobe),
    .a2mem_if         (bus)
  );

  // 100 MHz logic clock
  always #5 clk = ~clk;

  // Snapshot of the DUT outputs in the bench's comparison layout
  function automatic obs_t sample();
    obs_t o;
    o.store80      = bus.STORE80;
    o.ramrd        = bus.RAMRD;
    o.ramwrt       = bus.RAMWRT;
    o.altzp        = bus.ALTZP;
    o.col80        = bus.COL80;
    o.text_mode    = bus.TEXT_MODE;
    o.page2        = bus.PAGE2;
    o.hires        = bus.HIRES_MODE;
    o.intc8rom     = bus.INTC8ROM;
    o.slotrom      = bus.SLOTROM;
    o.aux_mem      = bus.aux_mem;
    o.keycode      = bus.keycode;
    o.kstrobe      = bus.keypress_strobe;
    o.text_color   = bus.TEXT_COLOR;
    o.bg_color     = bus.BACKGROUND_COLOR;
    o.border_color = bus.BORDER_COLOR;
    o.shrg         = bus.SHRG_MODE;
    o.linearize    = bus.LINEARIZE_MODE;
    return o;
  endfunction

  // Pop the oldest expected snapshot and compare against the DUT
  task automatic checkOutput(input string name);
    obs_t act;
    obs_t expv;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: scoreboard empty, no expected value", name);
    end else begin
      expv = exp_q.pop_front();
      act  = sample();
      if (act !== expv) begin
        errors++;
        $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
      end
    end
  endtask

  // Single-signal comparison
  task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Drive one bus strobe, queue its expected result and check one cycle later
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic rw, input obs_t e);
    addr   = a;
    data   = d;
    rw_n   = rw;
    strobe = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput($sformatf("access %04h rw=%0d", a, rw));
  endtask

  task automatic idleCycle();
    strobe = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic [15:0] a, input logic [7:0] d, input logic rw, input obs_t e);
    vec_t v;
    v.addr = a;
    v.data = d;
    v.rw_n = rw;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  // Main test sequence
  initial begin
    obs_t e;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(RST);
    checkOutput("reset state");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    e = RST;
    e.store80 = 1'b1;                        addVec(16'hC001, 8'h00, 1'b0, e);
    e.ramrd = 1'b1;                          addVec(16'hC003, 8'h00, 1'b0, e);
    e.col80 = 1'b1;                          addVec(16'hC00D, 8'h00, 1'b0, e);
                                             addVec(16'hC001, 8'h00, 1'b1, e);
    e.hires = 1'b1;                          addVec(16'hC057, 8'h00, 1'b1, e);
    e.page2 = 1'b1;                          addVec(16'hC055, 8'h00, 1'b1, e);
    e.aux_mem = 1'b1;                        addVec(16'h2000, 8'h00, 1'b1, e);
                                             addVec(16'h0400, 8'h00, 1'b1, e);
                                             addVec(16'h0800, 8'h00, 1'b1, e);
    e.aux_mem = 1'b0;                        addVec(16'h0800, 8'h00, 1'b0, e);
    e.page2 = 1'b0;                          addVec(16'hC054, 8'h00, 1'b1, e);
                                             addVec(16'h2000, 8'h00, 1'b0, e);
    e.store80 = 1'b0;                        addVec(16'hC000, 8'h00, 1'b0, e);
    e.aux_mem = 1'b1;                        addVec(16'h0400, 8'h00, 1'b1, e);
    e.aux_mem = 1'b0; e.text_mode = 1'b0;    addVec(16'hC050, 8'h00, 1'b0, e);
    e.altzp = 1'b1;                          addVec(16'hC009, 8'h00, 1'b0, e);
    e.aux_mem = 1'b1;                        addVec(16'h0100, 8'h00, 1'b1, e);
                                             addVec(16'hF000, 8'h00, 1'b0, e);
    e.aux_mem = 1'b0; e.altzp = 1'b0;        addVec(16'hC008, 8'h00, 1'b0, e);
    e.slotrom = 3'd6;                        addVec(16'hC600, 8'h00, 1'b1, e);
    e.intc8rom = 1'b1;                       addVec(16'hC300, 8'h00, 1'b1, e);
    e.intc8rom = 1'b0; e.slotrom = 3'd0;     addVec(16'hCFFF, 8'h00, 1'b0, e);
                                             addVec(16'hC007, 8'h00, 1'b0, e);
                                             addVec(16'hC500, 8'h00, 1'b1, e);
                                             addVec(16'hC006, 8'h00, 1'b0, e);
    e.slotrom = 3'd2;                        addVec(16'hC2FF, 8'h00, 1'b1, e);
                                             addVec(16'hC800, 8'h00, 1'b1, e);
                                             addVec(16'hC00B, 8'h00, 1'b0, e);
    e.slotrom = 3'd3;                        addVec(16'hC300, 8'h00, 1'b1, e);
    e.slotrom = 3'd0;                        addVec(16'hCFFF, 8'h00, 1'b1, e);
    e.keycode = 8'hC1; e.kstrobe = 1'b1;     addVec(16'hC000, 8'hC1, 1'b1, e);
    e.kstrobe = 1'b0;                        addVec(16'hC000, 8'hC2, 1'b1, e);
                                             addVec(16'hC010, 8'h00, 1'b0, e);
    e.keycode = 8'hC2; e.kstrobe = 1'b1;     addVec(16'hC000, 8'hC2, 1'b1, e);
    e.kstrobe = 1'b0;                        addVec(16'hC00F, 8'hC5, 1'b1, e);
                                             addVec(16'hC01F, 8'h00, 1'b1, e);
                                             addVec(16'hC000, 8'h41, 1'b1, e);
                                             addVec(16'hC000, 8'hC7, 1'b0, e);
    e.keycode = 8'hC8; e.kstrobe = 1'b1;     addVec(16'hC008, 8'hC8, 1'b1, e);
    e.kstrobe = 1'b0;
    if (IIGS) begin e.text_color = 4'h1; e.bg_color = 4'hE; end
                                             addVec(16'hC022, 8'h1E, 1'b0, e);
    if (IIGS) begin e.shrg = 1'b1; e.linearize = 1'b1; end
                                             addVec(16'hC029, 8'hC0, 1'b0, e);
                                             addVec(16'hC022, 8'h55, 1'b1, e);
    if (IIGS) e.border_color = 4'h3;         addVec(16'hC034, 8'hA3, 1'b0, e);
    if (IIGS) begin e.shrg = 1'b0; e.linearize = 1'b0; end
                                             addVec(16'hC029, 8'h00, 1'b0, e);
    e.text_mode = 1'b1;                      addVec(16'hC051, 8'h00, 1'b1, e);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].rw_n, vecs[i].exp);
      idleCycle();
      if (vecs[i].exp.kstrobe) begin
        checkValue($sformatf("keypress drop %0d", i), {7'd0, bus.keypress_strobe}, 8'h00);
      end
    end

    // Back-to-back strobes: each access sees the previous access's state
    e.store80 = 1'b1;
    applyStimulus(16'hC001, 8'h00, 1'b0, e);
    applyStimulus(16'h0400, 8'h00, 1'b1, e);
    e.page2 = 1'b1;
    applyStimulus(16'hC055, 8'h00, 1'b1, e);
    e.aux_mem = 1'b1;
    applyStimulus(16'h0400, 8'h00, 1'b1, e);

    // No strobe: a would-be write to $C000 must not clear STORE80
    addr = 16'hC000;
    rw_n = 1'b0;
    idleCycle();
    idleCycle();
    exp_q.push_back(e);
    checkOutput("hold without strobe");

    // Asynchronous reset between strobes, with a key pending
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(RST);
    checkOutput("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    e = RST;
    e.keycode = 8'hC3;
    e.kstrobe = 1'b1;
    applyStimulus(16'hC000, 8'hC3, 1'b1, e);
    idleCycle();
    checkValue("keypress drop after reset", {7'd0, bus.keypress_strobe}, 8'h00);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
